// File: rtl/ula_seq_if.sv
// rtl/ula_seq_if.sv - request/response bundle for the sequential ALU
// Purpose: groups the request handshake (in_valid/in_ready plus operands and
//          opcode) and the response handshake (out_valid/out_ready plus result
//          and flags) of ula_seq.
// Ports (signals):
//   in_valid, in_ready          request handshake
//   SrcA, SrcB [WIDTH]          operands (SrcB is the shift amount for shifts)
//   ULAControl [4]              opcode
//   out_valid, out_ready        response handshake
//   ULAResult [WIDTH]           result
//   Z, N, C, V, dz, illegal     flags registered with ULAResult
// Modports: master drives requests and consumes results, slave is the ALU.
interface ula_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ULAControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ULAResult;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;
    logic             dz;
    logic             illegal;

    modport master (
        output in_valid, SrcA, SrcB, ULAControl, out_ready,
        input  in_ready, out_valid, ULAResult, Z, N, C, V, dz, illegal
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ULAControl, out_ready,
        output in_ready, out_valid, ULAResult, Z, N, C, V, dz, illegal
    );
endinterface

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sequential ALU with optional shift-add multiply and restoring divide
// Purpose: accepts one operation per request, presents a registered result with
//          Z/N/C/V/dz/illegal flags and holds it until the consumer accepts it.
//          Single-cycle ops answer one cycle after acceptance; MUL/DIVU/REMU
//          iterate one bit per cycle for WIDTH cycles.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - ula_seq_if.slave (request/response handshake, operands, result, flags)
// Configuration: define ULA_SEQ_MULDIV_EN to build MUL/DIVU/REMU; otherwise
//   opcodes 1000/1001/1010 are answered as illegal and BUSY is unreachable.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    ula_seq_if.slave bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q;
    logic             n_q;
    logic             c_q;
    logic             v_q;
    logic             dz_q;
    logic             illegal_q;

    // Single-cycle datapath, evaluated on the live request inputs so the
    // result can be registered on the accepting edge.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        sum     = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
        diff    = {1'b0, bus.SrcA} - {1'b0, bus.SrcB};
        case (bus.ULAControl)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                // No borrow out means SrcA >= SrcB.
                alu_c   = ~diff[WIDTH];
                alu_v   = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.SrcA & bus.SrcB;
            OP_OR:   alu_res = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            OP_SRL:  alu_res = (bus.SrcB >= SHIFT_LIM) ? '0 : (bus.SrcA >> bus.SrcB);
            OP_SLL:  alu_res = (bus.SrcB >= SHIFT_LIM) ? '0 : (bus.SrcA << bus.SrcB);
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ULA_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // acc : running product (MUL) or partial remainder (DIVU/REMU)
    // opnd: shifting multiplicand (MUL) or fixed divisor
    // sh  : multiplier shifting right (MUL) or dividend shifting out / quotient shifting in
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             dz_pend;
    logic             is_md;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] opnd_nxt;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] md_res;

    assign is_md = (bus.ULAControl == OP_MUL) || (bus.ULAControl == OP_DIVU) ||
                   (bus.ULAControl == OP_REMU);

    always_comb begin
        acc_nxt   = acc;
        opnd_nxt  = opnd;
        sh_nxt    = sh;
        div_part  = {acc, sh[WIDTH-1]};
        div_trial = div_part - {1'b0, opnd};
        if (op_q == OP_MUL) begin
            acc_nxt  = sh[0] ? (acc + opnd) : acc;
            opnd_nxt = opnd << 1;
            sh_nxt   = sh >> 1;
        end else if (!div_trial[WIDTH]) begin
            // Trial subtraction fits: keep it and shift in a quotient 1.
            // A zero divisor always lands here, giving all-ones / SrcA.
            acc_nxt = div_trial[WIDTH-1:0];
            sh_nxt  = {sh[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = div_part[WIDTH-1:0];
            sh_nxt  = {sh[WIDTH-2:0], 1'b0};
        end
        md_res = (op_q == OP_DIVU) ? sh_nxt : acc_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b1;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            dz_q        <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ULA_SEQ_MULDIV_EN
            op_q        <= '0;
            acc         <= '0;
            opnd        <= '0;
            sh          <= '0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
`ifdef ULA_SEQ_MULDIV_EN
                        if (is_md) begin
                            state   <= S_BUSY;
                            op_q    <= bus.ULAControl;
                            acc     <= '0;
                            cnt     <= CNT_LAST;
                            dz_pend <= (bus.ULAControl != OP_MUL) && (bus.SrcB == '0);
                            if (bus.ULAControl == OP_MUL) begin
                                opnd <= bus.SrcA;
                                sh   <= bus.SrcB;
                            end else begin
                                opnd <= bus.SrcB;
                                sh   <= bus.SrcA;
                            end
                        end else
`endif
                        begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            z_q         <= (alu_res == '0);
                            n_q         <= alu_res[WIDTH-1];
                            c_q         <= alu_c;
                            v_q         <= alu_v;
                            dz_q        <= 1'b0;
                            illegal_q   <= alu_ill;
                        end
                    end
                end
                S_BUSY: begin
`ifdef ULA_SEQ_MULDIV_EN
                    acc  <= acc_nxt;
                    opnd <= opnd_nxt;
                    sh   <= sh_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_res;
                        z_q         <= (md_res == '0);
                        n_q         <= md_res[WIDTH-1];
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                        dz_q        <= dz_pend;
                        illegal_q   <= 1'b0;
                    end
`else
                    state      <= S_IDLE;
                    in_ready_q <= 1'b1;
`endif
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ULAResult = result_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.C         = c_q;
    assign bus.V         = v_q;
    assign bus.dz        = dz_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - directed vector bench for ula_seq (WIDTH=8)
module tb_ula_seq;

    logic clk;
    logic rst_n;

    ula_seq_if #(.WIDTH(8)) bus ();

    ula_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
        logic       dz;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] res,
                                logic z, logic n, logic c, logic v, logic dz, logic ill, int lat);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.res = res;
        t.z = z; t.n = n; t.c = c; t.v = v; t.dz = dz; t.ill = ill; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one request at a negedge and waits (bounded) for out_valid.
    // lat counts clock edges from acceptance edge to first out_valid.
    // With noise set, in_valid is re-asserted with another opcode after the
    // accepting edge to show that it is ignored.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit noise, output int lat);
        @(negedge clk);
        chk("in_ready_before_req", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid   = 1'b1;
        bus.ULAControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            bus.in_valid = noise && (lat >= 2) && (lat <= 4);
            if (noise) begin
                bus.ULAControl = 4'b0000;
                bus.SrcA       = 8'h01;
                bus.SrcB       = 8'h01;
            end
            if (bus.out_valid || lat >= 40) break;
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) chk("out_valid_timeout", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_out_valid_after_ack"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_in_ready_after_ack"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic check_vec(input string tag, input vec_t t, input int lat);
        chk({tag, "_lat"}, lat, t.lat);
        chk({tag, "_res"}, {24'b0, bus.ULAResult}, {24'b0, t.res});
        chk({tag, "_flags_zncv_dz_ill"},
            {26'b0, bus.Z, bus.N, bus.C, bus.V, bus.dz, bus.illegal},
            {26'b0, t.z, t.n, t.c, t.v, t.dz, t.ill});
        chk({tag, "_in_ready_done"}, {31'b0, bus.in_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        vec_t t;

        //                 op       a      b      res    z  n  c  v  dz il lat
        vecs.push_back(mk(4'b0000, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 8'h05, 8'h07, 8'hFE, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 8'h07, 8'h05, 8'h02, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 8'h33, 8'h33, 8'h00, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0011, 8'hF0, 8'h0F, 8'hFF, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0100, 8'hAA, 8'hAA, 8'h00, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0101, 8'h05, 8'h07, 8'h01, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0101, 8'h07, 8'h05, 8'h00, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0110, 8'h80, 8'h09, 8'h00, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0110, 8'h80, 8'h07, 8'h01, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0110, 8'h80, 8'h08, 8'h00, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0111, 8'h01, 8'h07, 8'h80, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0111, 8'h01, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1111, 8'h12, 8'h34, 8'h00, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1011, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 1, 1));
`ifdef ULA_SEQ_MULDIV_EN
        vecs.push_back(mk(4'b1000, 8'h0D, 8'h0B, 8'h8F, 0, 1, 0, 0, 0, 0, 9));
        vecs.push_back(mk(4'b1000, 8'hFF, 8'hFF, 8'h01, 0, 0, 0, 0, 0, 0, 9));
        vecs.push_back(mk(4'b1001, 8'h64, 8'h07, 8'h0E, 0, 0, 0, 0, 0, 0, 9));
        vecs.push_back(mk(4'b1010, 8'h64, 8'h07, 8'h02, 0, 0, 0, 0, 0, 0, 9));
        vecs.push_back(mk(4'b1001, 8'h33, 8'h00, 8'hFF, 0, 1, 0, 0, 1, 0, 9));
        vecs.push_back(mk(4'b1010, 8'h33, 8'h00, 8'h33, 0, 0, 0, 0, 1, 0, 9));
        vecs.push_back(mk(4'b1001, 8'h05, 8'h07, 8'h00, 1, 0, 0, 0, 0, 0, 9));
`else
        vecs.push_back(mk(4'b1000, 8'h03, 8'h03, 8'h00, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1001, 8'h64, 8'h07, 8'h00, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1010, 8'h64, 8'h07, 8'h00, 1, 0, 0, 0, 0, 1, 1));
`endif

        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ULAControl = 4'b0000;
        bus.SrcA       = 8'h00;
        bus.SrcB       = 8'h00;
        rst_n          = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_result", {24'b0, bus.ULAResult}, 32'd0);
        chk("reset_flags_zncv_dz_ill",
            {26'b0, bus.Z, bus.N, bus.C, bus.V, bus.dz, bus.illegal}, 32'b100000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            issue(t.op, t.a, t.b, 1'b0, lat);
            check_vec($sformatf("vec%0d_op%0h", i, t.op), t, lat);
            release_out($sformatf("vec%0d", i));
        end

        // Hold in DONE with out_ready low; in_valid pulses must be ignored.
        t = mk(4'b0000, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 0, 0, 1);
        issue(t.op, t.a, t.b, 1'b0, lat);
        check_vec("stall_first", t, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid   = (k == 1) || (k == 2);
            bus.ULAControl = 4'b0000;
            bus.SrcA       = 8'h01;
            bus.SrcB       = 8'h01;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_out_valid", k), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("stall%0d_in_ready", k), {31'b0, bus.in_ready}, 32'd0);
            chk($sformatf("stall%0d_res", k), {24'b0, bus.ULAResult}, 32'h80);
            chk($sformatf("stall%0d_nv", k), {30'b0, bus.N, bus.V}, 32'b11);
        end
        bus.in_valid = 1'b0;
        release_out("stall");
        t = mk(4'b0101, 8'h05, 8'h07, 8'h01, 0, 0, 0, 0, 0, 0, 1);
        issue(t.op, t.a, t.b, 1'b0, lat);
        check_vec("after_stall", t, lat);
        release_out("after_stall");

`ifdef ULA_SEQ_MULDIV_EN
        // in_valid pulses during BUSY are ignored.
        t = mk(4'b1001, 8'h64, 8'h07, 8'h0E, 0, 0, 0, 0, 0, 0, 9);
        issue(t.op, t.a, t.b, 1'b1, lat);
        check_vec("busy_noise", t, lat);
        release_out("busy_noise");
        @(posedge clk);
        #1;
        chk("busy_noise_no_extra_result", {31'b0, bus.out_valid}, 32'd0);

        // Reset at cycle 4 of a DIVU.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.ULAControl = 4'b1001;
        bus.SrcA       = 8'h64;
        bus.SrcB       = 8'h07;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
`else
        // Reset while a result is waiting in DONE.
        issue(4'b0011, 8'h5A, 8'h00, 1'b0, lat);
        chk("pre_reset_res", {24'b0, bus.ULAResult}, 32'h5A);
        #1;
`endif
        rst_n = 1'b0;
        #1;
        chk("midop_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midop_reset_result", {24'b0, bus.ULAResult}, 32'd0);
        chk("midop_reset_z", {31'b0, bus.Z}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_reset%0d_out_valid", k), {31'b0, bus.out_valid}, 32'd0);
        end

        // First request accepted on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ULAControl = 4'b0000;
        bus.SrcA       = 8'h02;
        bus.SrcB       = 8'h03;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("first_edge_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("first_edge_res", {24'b0, bus.ULAResult}, 32'h05);
        release_out("first_edge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (SHALL be >= 4).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 SrcA  input  WIDTH  operand A, unsigned.
REQ-007 SrcB  input  WIDTH  operand B, unsigned (shift amount for shifts).
REQ-008 ULAControl  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLTU, 0110 SRL, 0111 SLL, 1000 MUL, 1001 DIVU, 1010 REMU, others illegal.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ULAResult  output  WIDTH  registered result.
REQ-012 Z, N, C, V  output  1 each  zero, sign (MSB), carry, signed overflow flags.
REQ-013 dz  output  1  divide-by-zero occurred (DIVU/REMU with SrcB=0).
REQ-014 illegal  output  1  opcode illegal or not compiled in.

Function
REQ-015 FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Request SHALL be accepted on a clk edge with in_valid=1 and in_ready=1; operands and opcode SHALL be captured then; inputs are don't-care otherwise.
REQ-017 Ops 0000-0111 and illegal opcodes SHALL go IDLE->DONE; out_valid rises 1 cycle after acceptance.
REQ-018 MUL/DIVU/REMU SHALL go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles, then BUSY->DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 DONE->IDLE SHALL occur on the edge with out_ready=1; outputs SHALL hold stable in DONE while out_ready=0.
REQ-020 ADD/SUB SHALL be modulo 2^WIDTH; C = carry-out for ADD, C = 1 when SrcA>=SrcB for SUB; V = two's-complement overflow for ADD/SUB; C=V=0 for all other ops.
REQ-021 SLTU SHALL give 1 if SrcA<SrcB unsigned, else 0.
REQ-022 SRL/SLL SHALL be logical; shift amount = full SrcB value; amount >= WIDTH SHALL give 0.
REQ-023 MUL SHALL give low WIDTH bits of the unsigned product (shift-add).
REQ-024 DIVU/REMU SHALL give unsigned quotient/remainder (restoring division); SrcB=0 SHALL give quotient all-ones, remainder SrcA, dz=1, without early exit (still WIDTH BUSY cycles).
REQ-025 Illegal opcode SHALL give ULAResult=0, illegal=1, flags computed on that result.
REQ-026 Z = (ULAResult==0), N = ULAResult[WIDTH-1], for every op; flags, dz, illegal SHALL be registered with ULAResult and valid whenever out_valid=1.
REQ-027 in_valid during BUSY or DONE SHALL be ignored (no queuing).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, ULAResult=0, Z=1, N=C=V=0, dz=0, illegal=0, out_valid=0, in_ready=1 (in_ready may be 0 while rst_n=0).
REQ-029 Reset in BUSY or DONE SHALL discard the operation; no result SHALL be presented after release.
REQ-030 First request SHALL be accepted on the first clk edge after rst_n deasserts.

Configuration
REQ-031 Macro ULA_SEQ_MULDIV_EN: defined -> MUL/DIVU/REMU per REQ-018/023/024 and BUSY state present.
REQ-032 Not defined -> 1000/1001/1010 SHALL be illegal per REQ-025 with 1-cycle latency, no multiply/divide logic, BUSY unreachable.

Verification
REQ-033 WIDTH=8: ADD 0xFF+0x01 -> out_valid after 1 cycle, ULAResult=0x00, Z=1, C=1, V=0; ADD 0x7F+0x01 -> 0x80, N=1, V=1.
REQ-034 SUB 0x05-0x07 -> 0xFE, C=0, N=1; SLTU 0x05,0x07 -> 0x01; SRL 0x80 by 0x09 -> 0x00, Z=1; SLL 0x01 by 0x07 -> 0x80.
REQ-035 MULDIV_EN: MUL 0x0D*0x0B -> 0x8F after 9 cycles; DIVU 0x64/0x07 -> 0x0E; REMU 0x64,0x07 -> 0x02; DIVU 0x33/0x00 -> 0xFF, dz=1; in_valid pulses during BUSY ignored.
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, next request accepted.
REQ-037 rst_n asserted at cycle 4 of a DIVU -> out_valid=0, ULAResult=0 immediately; no stale result after release.
REQ-038 Without ULA_SEQ_MULDIV_EN: MUL 0x03*0x03 -> 1-cycle latency, ULAResult=0x00, illegal=1, Z=1; opcode 1111 -> same response.
